// File: rtl/rf_write_strobe_gen.sv
// Per-channel phase counters generating single-cycle register-file write
// strobes and end-of-instruction pulses for the multi-cycle datapath.
module rf_write_strobe_gen #(
  parameter int NUM_CH  = 2,
  parameter int PHASE_W = 2
) (
  input  logic                      RFWSTB_Clk,
  input  logic                      RFWSTB_Reset,
  input  logic [NUM_CH-1:0]         RFWSTB_En,
  input  logic                      RFWSTB_Stall,
  input  logic                      RFWSTB_Mode,
  input  logic [PHASE_W-1:0]        RFWSTB_Cpi,
  input  logic [PHASE_W-1:0]        RFWSTB_WritePhase,
  output logic [NUM_CH-1:0]         RFWSTB_Write,
  output logic [NUM_CH-1:0]         RFWSTB_Done,
  output logic [NUM_CH-1:0]         RFWSTB_Busy,
  output logic [NUM_CH*PHASE_W-1:0] RFWSTB_Phase
);

  logic [PHASE_W-1:0] phase [NUM_CH];
  logic [NUM_CH-1:0]  fired;
  logic [NUM_CH-1:0]  act;
  logic [NUM_CH-1:0]  term;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // >= lets a mid-instruction Cpi reduction terminate immediately
    assign term[i] = (phase[i] >= RFWSTB_Cpi);
    assign act[i]  = RFWSTB_En[i] & ~RFWSTB_Stall & ~fired[i];

    always_ff @(posedge RFWSTB_Clk) begin
      if (RFWSTB_Reset) begin
        phase[i] <= '0;
        fired[i] <= 1'b0;
      end else if (!RFWSTB_En[i]) begin
        phase[i] <= '0;
        fired[i] <= 1'b0;
      end else if (act[i]) begin
        if (term[i]) begin
          phase[i] <= '0;
          fired[i] <= RFWSTB_Mode;
        end else begin
          phase[i] <= phase[i] + PHASE_W'(1);
        end
      end
    end

    assign RFWSTB_Write[i] = ~RFWSTB_Reset & act[i]
                           & (phase[i] == RFWSTB_WritePhase);
    assign RFWSTB_Done[i]  = ~RFWSTB_Reset & act[i] & term[i];
    assign RFWSTB_Busy[i]  = ~RFWSTB_Reset & RFWSTB_En[i] & ~fired[i];
    assign RFWSTB_Phase[i*PHASE_W +: PHASE_W] = phase[i];
  end

endmodule

// File: tb/tb_rf_write_strobe_gen.sv
// Directed bench for rf_write_strobe_gen: hand-computed strobe patterns
// checked cycle by cycle with immediate assertions.
module tb_rf_write_strobe_gen;

  logic       clk;
  logic       rst;
  logic [1:0] en;
  logic       stall;
  logic       mode;
  logic [1:0] cpi;
  logic [1:0] wp;
  logic [1:0] wr;
  logic [1:0] dn;
  logic [1:0] bsy;
  logic [3:0] ph;

  int n_assert = 0;
  int n_fail   = 0;

  rf_write_strobe_gen #(.NUM_CH(2), .PHASE_W(2)) dut (
    .RFWSTB_Clk        (clk),
    .RFWSTB_Reset      (rst),
    .RFWSTB_En         (en),
    .RFWSTB_Stall      (stall),
    .RFWSTB_Mode       (mode),
    .RFWSTB_Cpi        (cpi),
    .RFWSTB_WritePhase (wp),
    .RFWSTB_Write      (wr),
    .RFWSTB_Done       (dn),
    .RFWSTB_Busy       (bsy),
    .RFWSTB_Phase      (ph)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [3:0] exp);
    chk({tag, ".phase"}, {4'b0, ph}, {4'b0, exp});
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, then advances.
  task automatic cyc(input string tag, input logic [1:0] w,
                     input logic [1:0] d, input logic [1:0] b);
    #4;
    chk({tag, ".write"}, {6'b0, wr},  {6'b0, w});
    chk({tag, ".done"},  {6'b0, dn},  {6'b0, d});
    chk({tag, ".busy"},  {6'b0, bsy}, {6'b0, b});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 2'b11; stall = 1'b0; mode = 1'b0;
    cpi = 2'd1; wp = 2'd0;
    #1;
    cyc("rst0", 2'b00, 2'b00, 2'b00);
    chkp("rst1", 4'h0);
    cyc("rst1", 2'b00, 2'b00, 2'b00);
    en = 2'b00;
    rst = 1'b0;
    cyc("idle", 2'b00, 2'b00, 2'b00);

    // Legacy pattern: Cpi=1, WritePhase=0, periodic
    en = 2'b01;
    for (int k = 0; k < 6; k++)
      cyc($sformatf("dflt%0d", k), {1'b0, k % 2 == 0},
          {1'b0, k % 2 == 1}, 2'b01);
    en = 2'b00;
    cyc("dflt_off", 2'b00, 2'b00, 2'b00);

    // One-shot, Cpi=3, WritePhase=2
    mode = 1'b1; cpi = 2'd3; wp = 2'd2; en = 2'b01;
    for (int k = 0; k < 8; k++)
      cyc($sformatf("os%0d", k), {1'b0, k == 2},
          {1'b0, k == 3}, {1'b0, k < 4});
    en = 2'b00;
    cyc("os_off", 2'b00, 2'b00, 2'b00);
    en = 2'b01;
    for (int k = 0; k < 4; k++)
      cyc($sformatf("os_re%0d", k), {1'b0, k == 2},
          {1'b0, k == 3}, 2'b01);
    en = 2'b00;
    cyc("os_off2", 2'b00, 2'b00, 2'b00);

    // Stall cycles 2-3 delay the write to cycle 4
    mode = 1'b0; en = 2'b01;
    cyc("st0", 2'b00, 2'b00, 2'b01);
    cyc("st1", 2'b00, 2'b00, 2'b01);
    stall = 1'b1;
    chkp("st2", 4'h2);
    cyc("st2", 2'b00, 2'b00, 2'b01);
    chkp("st3", 4'h2);
    cyc("st3", 2'b00, 2'b00, 2'b01);
    stall = 1'b0;
    chkp("st4", 4'h2);
    cyc("st4", 2'b01, 2'b00, 2'b01);
    cyc("st5", 2'b00, 2'b01, 2'b01);
    en = 2'b00;
    cyc("st_off", 2'b00, 2'b00, 2'b00);

    // WritePhase beyond Cpi: never writes, Done every 3 cycles
    cpi = 2'd2; wp = 2'd3; en = 2'b01;
    for (int k = 0; k < 9; k++)
      cyc($sformatf("nw%0d", k), 2'b00, {1'b0, k % 3 == 2}, 2'b01);
    en = 2'b00;
    cyc("nw_off", 2'b00, 2'b00, 2'b00);

    // Cpi=0: Write and Done every active cycle
    cpi = 2'd0; wp = 2'd0; en = 2'b01;
    for (int k = 0; k < 3; k++)
      cyc($sformatf("c0_%0d", k), 2'b01, 2'b01, 2'b01);
    en = 2'b00;
    cyc("c0_off", 2'b00, 2'b00, 2'b00);

    // Cpi reduced below the current phase terminates at once
    cpi = 2'd3; wp = 2'd0; en = 2'b01;
    cyc("cr0", 2'b01, 2'b00, 2'b01);
    cyc("cr1", 2'b00, 2'b00, 2'b01);
    cpi = 2'd1;
    chkp("cr2", 4'h2);
    cyc("cr2", 2'b00, 2'b01, 2'b01);
    chkp("cr3", 4'h0);
    cyc("cr3", 2'b01, 2'b00, 2'b01);
    cyc("cr4", 2'b00, 2'b01, 2'b01);
    en = 2'b00;
    cyc("cr_off", 2'b00, 2'b00, 2'b00);

    // Abort at phase 3 (terminal, wrap case) leaves no residue
    cpi = 2'd3; wp = 2'd3; en = 2'b01;
    cyc("ab0", 2'b00, 2'b00, 2'b01);
    cyc("ab1", 2'b00, 2'b00, 2'b01);
    cyc("ab2", 2'b00, 2'b00, 2'b01);
    chkp("ab3", 4'h3);
    en = 2'b00;
    cyc("ab3", 2'b00, 2'b00, 2'b00);
    chkp("ab4", 4'h0);
    cyc("ab4", 2'b00, 2'b00, 2'b00);

    // Offset channels, reset pulse realigns them
    wp = 2'd0; en = 2'b01;
    cyc("rr0", 2'b01, 2'b00, 2'b01);
    en = 2'b11;
    cyc("rr1", 2'b10, 2'b00, 2'b11);
    chkp("rr2", 4'b0110);
    cyc("rr2", 2'b00, 2'b00, 2'b11);
    rst = 1'b1;
    cyc("rr3", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    chkp("rr4", 4'h0);
    cyc("rr4", 2'b11, 2'b00, 2'b11);
    chkp("rr5", 4'b0101);
    cyc("rr5", 2'b00, 2'b00, 2'b11);
    en = 2'b00;
    cyc("rr_off", 2'b00, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
